// File: rtl/piso_tx_if.sv
// Load handshake and serial output bundle for the piso_tx transmitter.
// master = word source / serial sink side, slave = transmitter side.
interface piso_tx_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] din;
  logic             so;
  logic             so_valid;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, din,
    input  load_ready, so, so_valid, busy, done
  );

  modport slave (
    input  load_valid, din,
    output load_ready, so, so_valid, busy, done
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: takes a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per clock, streaming words with no gap.
//
//   state | meaning
//   IDLE  | no word in flight; so/so_valid low, ready for a word
//   SHIFT | word on so, one bit per cycle; reloads at the last bit if offered
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  piso_tx_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shifted;
  logic [CNT_W-1:0] r_cnt;
  logic             w_shifting;
  logic             w_last;
  logic             w_ready;
  logic             w_accept;
  logic             w_out_bit;

  assign w_shifting = (r_state == SHIFT);
  assign w_last     = w_shifting && (r_cnt == LAST_CNT);
  assign w_ready    = (r_state == IDLE) || w_last;
  assign w_accept   = bus.load_valid && w_ready;

  // Shift toward the output end so the next transmit bit is always at the tap.
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shifted = {r_shreg[WIDTH-2:0], 1'b0};
      assign w_out_bit = r_shreg[WIDTH-1];
    end else begin : g_lsb
      assign w_shifted = {1'b0, r_shreg[WIDTH-1:1]};
      assign w_out_bit = r_shreg[0];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:  if (w_accept) w_next_state = SHIFT;
      SHIFT: if (w_last && !w_accept) w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_shreg <= bus.din;
      r_cnt   <= '0;
    end else if (w_shifting) begin
      r_shreg <= w_shifted;
      r_cnt   <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Outputs depend only on registered state; din never reaches so directly.
  assign bus.so         = w_shifting & w_out_bit;
  assign bus.so_valid   = w_shifting;
  assign bus.busy       = w_shifting;
  assign bus.done       = w_last;
  assign bus.load_ready = w_ready;

endmodule

// File: tb/tb_piso_tx.sv
// Scoreboard bench for piso_tx: MSB-first and LSB-first 8-bit instances plus a
// 4-bit instance looped back into a small serial receiver.
module tb_piso_tx;

  typedef struct packed {
    logic so;
    logic done;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t q_c[$];
  logic [3:0] rx_word;

  piso_tx_if #(.WIDTH(8)) ifa ();
  piso_tx_if #(.WIDTH(8)) ifb ();
  piso_tx_if #(.WIDTH(4)) ifc ();

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  piso_tx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial receiver fed from the 4-bit transmitter, MSB arrives first.
  always_ff @(posedge clk) begin
    if (ifc.so_valid) rx_word <= {rx_word[2:0], ifc.so};
  end

  task automatic push_a(input logic [7:0] w);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.so = w[7-k]; e.done = (k == 7); q_a.push_back(e);
    end
  endtask

  task automatic push_b(input logic [7:0] w);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.so = w[k]; e.done = (k == 7); q_b.push_back(e);
    end
  endtask

  task automatic push_c(input logic [3:0] w);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.so = w[3-k]; e.done = (k == 3); q_c.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifa.load_valid = 1'b0; ifa.din = '0;
    ifb.load_valid = 1'b0; ifb.din = '0;
    ifc.load_valid = 1'b0; ifc.din = '0;
    #3;
    n_checks++;
    if ({ifa.so, ifa.so_valid, ifa.busy, ifa.done, ifa.load_ready} !== 5'b00001)
      $display("FAIL reset_a: so/so_valid/busy/done/ready=%b want 00001",
               {ifa.so, ifa.so_valid, ifa.busy, ifa.done, ifa.load_ready});
    else n_pass++;
    n_checks++;
    if ({ifb.so_valid, ifb.done, ifb.load_ready, ifc.so_valid, ifc.done, ifc.load_ready} !== 6'b001001)
      $display("FAIL reset_bc: flags=%b want 001001",
               {ifb.so_valid, ifb.done, ifb.load_ready, ifc.so_valid, ifc.done, ifc.load_ready});
    else n_pass++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_msb(input logic [7:0] w, input string name);
    exp_t e;
    @(negedge clk);
    ifa.din = w; ifa.load_valid = 1'b1; push_a(w);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin ifa.load_valid = 1'b0; ifa.din = ~w; end
      if (q_a.size() == 0) begin
        n_checks++;
        if ({ifa.so, ifa.so_valid, ifa.busy, ifa.done} !== 4'b0000)
          $display("FAIL %s_idle: so/so_valid/busy/done=%b want 0000", name,
                   {ifa.so, ifa.so_valid, ifa.busy, ifa.done});
        else n_pass++;
        break;
      end
      if (i == 3) begin
        n_checks++;
        if (ifa.load_ready !== 1'b0) $display("FAIL %s_ready_mid: got %b want 0", name, ifa.load_ready);
        else n_pass++;
      end
      e = q_a.pop_front();
      n_checks++;
      if ({ifa.so_valid, ifa.so, ifa.done} !== {1'b1, e.so, e.done})
        $display("FAIL %s_bit%0d: valid/so/done=%b want %b", name, i,
                 {ifa.so_valid, ifa.so, ifa.done}, {1'b1, e.so, e.done});
      else n_pass++;
    end
    n_checks++;
    if (q_a.size() != 0) begin $display("FAIL %s_timeout: %0d bits left want 0", name, q_a.size()); q_a.delete(); end
    else n_pass++;
  endtask

  task automatic test_lsb();
    exp_t e;
    @(negedge clk);
    ifb.din = 8'hB4; ifb.load_valid = 1'b1; push_b(8'hB4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) ifb.load_valid = 1'b0;
      if (q_b.size() == 0) begin
        n_checks++;
        if ({ifb.so, ifb.so_valid, ifb.busy, ifb.done} !== 4'b0000)
          $display("FAIL lsb_idle: so/so_valid/busy/done=%b want 0000",
                   {ifb.so, ifb.so_valid, ifb.busy, ifb.done});
        else n_pass++;
        break;
      end
      e = q_b.pop_front();
      n_checks++;
      if ({ifb.so_valid, ifb.so, ifb.done} !== {1'b1, e.so, e.done})
        $display("FAIL lsb_bit%0d: valid/so/done=%b want %b", i,
                 {ifb.so_valid, ifb.so, ifb.done}, {1'b1, e.so, e.done});
      else n_pass++;
    end
    n_checks++;
    if (q_b.size() != 0) begin $display("FAIL lsb_timeout: %0d bits left want 0", q_b.size()); q_b.delete(); end
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    @(negedge clk);
    ifa.din = 8'hA5; ifa.load_valid = 1'b1; push_a(8'hA5); push_a(8'h3C);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) ifa.din = 8'h3C;
      if (i == 8) ifa.load_valid = 1'b0;
      if (q_a.size() == 0) begin
        n_checks++;
        if ({ifa.so_valid, ifa.busy, ifa.done} !== 3'b000)
          $display("FAIL b2b_idle: so_valid/busy/done=%b want 000", {ifa.so_valid, ifa.busy, ifa.done});
        else n_pass++;
        break;
      end
      if (i == 7) begin
        n_checks++;
        if (ifa.load_ready !== 1'b1) $display("FAIL b2b_ready_last: got %b want 1", ifa.load_ready);
        else n_pass++;
      end
      e = q_a.pop_front();
      n_checks++;
      if ({ifa.so_valid, ifa.so, ifa.done} !== {1'b1, e.so, e.done})
        $display("FAIL b2b_bit%0d: valid/so/done=%b want %b", i,
                 {ifa.so_valid, ifa.so, ifa.done}, {1'b1, e.so, e.done});
      else n_pass++;
    end
    n_checks++;
    if (q_a.size() != 0) begin $display("FAIL b2b_timeout: %0d bits left want 0", q_a.size()); q_a.delete(); end
    else n_pass++;
  endtask

  // Phase 0: a one-cycle load_valid pulse mid-word is ignored.
  // Phase 1: load_valid raised mid-word and held is taken at the last bit.
  task automatic test_busy();
    exp_t e;
    for (int ph = 0; ph < 2; ph++) begin
      @(negedge clk);
      ifa.din = 8'hF0; ifa.load_valid = 1'b1; push_a(8'hF0);
      if (ph == 1) push_a(8'h0F);
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (i == 0) ifa.load_valid = 1'b0;
        if (i == 3) begin ifa.din = 8'h0F; ifa.load_valid = 1'b1; end
        if (i == 4 && ph == 0) ifa.load_valid = 1'b0;
        if (i == 8 && ph == 1) ifa.load_valid = 1'b0;
        if (q_a.size() == 0) begin
          n_checks++;
          if ({ifa.so_valid, ifa.busy, ifa.done} !== 3'b000)
            $display("FAIL busy%0d_idle: so_valid/busy/done=%b want 000", ph,
                     {ifa.so_valid, ifa.busy, ifa.done});
          else n_pass++;
          break;
        end
        if (i == 3) begin
          n_checks++;
          if (ifa.load_ready !== 1'b0) $display("FAIL busy%0d_ready: got %b want 0", ph, ifa.load_ready);
          else n_pass++;
        end
        e = q_a.pop_front();
        n_checks++;
        if ({ifa.so_valid, ifa.so, ifa.done} !== {1'b1, e.so, e.done})
          $display("FAIL busy%0d_bit%0d: valid/so/done=%b want %b", ph, i,
                   {ifa.so_valid, ifa.so, ifa.done}, {1'b1, e.so, e.done});
        else n_pass++;
      end
      n_checks++;
      if (q_a.size() != 0) begin $display("FAIL busy%0d_timeout: %0d bits left want 0", ph, q_a.size()); q_a.delete(); end
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    @(negedge clk);
    ifa.din = 8'hFF; ifa.load_valid = 1'b1; push_a(8'hFF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) ifa.load_valid = 1'b0;
      e = q_a.pop_front();
      n_checks++;
      if ({ifa.so_valid, ifa.so, ifa.done} !== {1'b1, e.so, e.done})
        $display("FAIL arst_bit%0d: valid/so/done=%b want %b", i,
                 {ifa.so_valid, ifa.so, ifa.done}, {1'b1, e.so, e.done});
      else n_pass++;
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({ifa.so, ifa.so_valid, ifa.busy, ifa.done, ifa.load_ready} !== 5'b00001)
      $display("FAIL arst_immediate: so/so_valid/busy/done/ready=%b want 00001",
               {ifa.so, ifa.so_valid, ifa.busy, ifa.done, ifa.load_ready});
    else n_pass++;
    q_a.delete();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({ifa.so_valid, ifa.done} !== 2'b00)
      $display("FAIL arst_held: so_valid/done=%b want 00", {ifa.so_valid, ifa.done});
    else n_pass++;
    rst = 1'b1;
    test_msb(8'h81, "post_rst");
  endtask

  task automatic test_loopback();
    exp_t e;
    bit   got_done;
    got_done = 1'b0;
    @(negedge clk);
    ifc.din = 4'b1011; ifc.load_valid = 1'b1; push_c(4'b1011);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin ifc.load_valid = 1'b0; ifc.din = 4'b0000; end
      if (q_c.size() == 0) begin
        n_checks++;
        if (!got_done || rx_word !== 4'b1011)
          $display("FAIL loopback_rx: rx=%b done_seen=%0d want 1011 done_seen=1", rx_word, got_done);
        else n_pass++;
        break;
      end
      e = q_c.pop_front();
      if (ifc.done === 1'b1) got_done = 1'b1;
      n_checks++;
      if ({ifc.so_valid, ifc.so, ifc.done} !== {1'b1, e.so, e.done})
        $display("FAIL loopback_bit%0d: valid/so/done=%b want %b", i,
                 {ifc.so_valid, ifc.so, ifc.done}, {1'b1, e.so, e.done});
      else n_pass++;
    end
    n_checks++;
    if (q_c.size() != 0) begin $display("FAIL loopback_timeout: %0d bits left want 0", q_c.size()); q_c.delete(); end
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_msb(8'hB4, "msb");
    test_lsb();
    test_back_to_back();
    test_busy();
    test_async_reset();
    test_loopback();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
